// File: rtl/ser2par_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: bit-order
// encodings and the bit-counter width helper.
package ser2par_pkg;

  localparam bit BIT_ORDER_LSB = 1'b0;
  localparam bit BIT_ORDER_MSB = 1'b1;

  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser2par_shift_core.sv
// Shift register and bit counter with frame-start alignment; flags the cycle
// in which the last bit of a word is accepted and presents the assembled word.
module ser2par_shift_core
  import ser2par_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  input  logic             si_valid,
  input  logic             frame_start,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] sr_q, sr_d, base_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;

  // Next shift-register/counter state; a frame start restarts the word at this bit
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    base_s     = sr_q;
    cnt_base_s = cnt_q;
    word_done  = 1'b0;
    if (si_valid) begin
      if (frame_start) begin
        base_s     = {WIDTH{1'b0}};
        cnt_base_s = {CNT_W{1'b0}};
      end else begin
        base_s     = sr_q;
        cnt_base_s = cnt_q;
      end
      if (MSB_FIRST == BIT_ORDER_MSB) begin
        sr_d = {base_s[WIDTH-2:0], si};
      end else begin
        sr_d = {si, base_s[WIDTH-1:1]};
      end
      if (cnt_base_s == CNT_W'(WIDTH - 1)) begin
        word_done = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
      end else begin
        word_done = 1'b0;
        cnt_d     = cnt_base_s + CNT_W'(1);
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and bit counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word    = sr_d;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/ser2par_deserializer.sv
// Parametrised serial-in/parallel-out deserializer with a held output word,
// valid/ready handshake and a sticky overrun flag for dropped words.
module ser2par_deserializer
  import ser2par_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  input  logic             si_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             word_done_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             drop_s;

  ser2par_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .si         (si),
    .si_valid   (si_valid),
    .frame_start(frame_start),
    .word_done  (word_done_s),
    .word       (word_s),
    .bit_cnt    (bit_cnt)
  );

  // Output word and handshake; a completed word is never stalled, only dropped
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_s  = word_done_s & valid_q & ~par_ready;
    if (word_done_s) begin
      if (!valid_q || par_ready) begin
        data_d  = word_s;
        valid_d = 1'b1;
      end else begin
        data_d  = data_q;
        valid_d = valid_q;
      end
    end else if (valid_q && par_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign par_data  = data_q;
  assign par_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ser2par_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances driven in lockstep and
// compared against a bit-queue reference model, table vectors and corner sequences.
module tb_ser2par_deserializer;

  localparam int W = 8;

  logic       clk, reset, si, si_valid, frame_start, par_ready, clr_overrun;
  logic [7:0] pd_l, pd_m;
  logic       pv_l, pv_m, ov_l, ov_m;
  logic [2:0] bc_l, bc_m;

  ser2par_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .frame_start(frame_start),
    .par_data(pd_l), .par_valid(pv_l), .par_ready(par_ready), .overrun(ov_l),
    .clr_overrun(clr_overrun), .bit_cnt(bc_l));

  ser2par_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .frame_start(frame_start),
    .par_data(pd_m), .par_valid(pv_m), .par_ready(par_ready), .overrun(ov_m),
    .clr_overrun(clr_overrun), .bit_cnt(bc_m));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: bits of the current partial word, in arrival order
  bit         q[$];
  bit         m_valid, m_ovr;
  logic [7:0] m_dl, m_dm;

  typedef struct {
    bit si; bit v; bit fs; bit rdy; bit clr;
    bit ev; logic [7:0] edl; logic [7:0] edm; logic [2:0] ecnt;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dl    = 8'h00;
    m_dm    = 8'h00;
  endtask

  task automatic model_edge(input bit s, input bit v, input bit fs, input bit rdy, input bit clr);
    bit done = 1'b0;
    bit drop;
    logic [7:0] wl, wm;
    wl = 8'h00;
    wm = 8'h00;
    if (v) begin
      if (fs) q.delete();
      q.push_back(s);
      if (q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = q[i];
          wm[W-1-i]   = q[i];
        end
        q.delete();
        done = 1'b1;
      end
    end
    drop = done && m_valid && !rdy;
    if (done) begin
      if (!m_valid || rdy) begin
        m_dl = wl;
        m_dm = wm;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic step(input bit s, input bit v, input bit fs, input bit rdy, input bit clr);
    si = s; si_valid = v; frame_start = fs; par_ready = rdy; clr_overrun = clr;
    model_edge(s, v, fs, rdy, clr);
    @(posedge clk);
    #1;
    chk("bit_cnt_lsb", bc_l, q.size());
    chk("bit_cnt_msb", bc_m, q.size());
    chk("par_valid_lsb", pv_l, m_valid);
    chk("par_valid_msb", pv_m, m_valid);
    chk("overrun_lsb", ov_l, m_ovr);
    chk("overrun_msb", ov_m, m_ovr);
    if (m_valid) begin
      chk("par_data_lsb", pd_l, m_dl);
      chk("par_data_msb", pd_m, m_dm);
    end
  endtask

  task automatic send_word(input logic [7:0] val, input int gap, input bit rdy,
                           input bit rdy_last, input bit fs);
    for (int i = 0; i < W; i++) begin
      step(val[i], 1'b1, fs && (i == 0), (i == W - 1) ? rdy_last : rdy, 1'b0);
      if (i != W - 1) repeat (gap) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] held;
    clk = 1'b0; reset = 1'b0; si = 1'b0; si_valid = 1'b0; frame_start = 1'b0;
    par_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    #12;
    chk("reset_data", pd_l, 8'h00);
    chk("reset_valid", pv_l, 1'b0);
    chk("reset_ovr", ov_l, 1'b0);
    chk("reset_cnt", bc_l, 3'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Stream 1,0,1,1,0,0,1,0 gives 4D LSB-first and B2 MSB-first
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{si: pat[i], v: 1'b1, fs: 1'b0, rdy: 1'b1, clr: 1'b0,
                 ev: (i == 7), edl: (i == 7) ? 8'h4D : 8'h00,
                 edm: (i == 7) ? 8'hB2 : 8'h00, ecnt: 3'((i + 1) % 8)};
    end
    tbl[8] = '{si: 1'b0, v: 1'b0, fs: 1'b0, rdy: 1'b1, clr: 1'b0,
               ev: 1'b0, edl: 8'h00, edm: 8'h00, ecnt: 3'd0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].si, tbl[i].v, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
      chk("tbl_valid", pv_l, tbl[i].ev);
      chk("tbl_cnt", bc_l, tbl[i].ecnt);
      if (tbl[i].ev) begin
        chk("tbl_data_lsb", pd_l, tbl[i].edl);
        chk("tbl_data_msb", pd_m, tbl[i].edm);
      end
    end

    // Gapped input: counter holds through idle cycles
    for (int i = 0; i < 8; i++) begin
      step(pat[i] ^ 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
      held = bc_l;
      if (i != 7) begin
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("gap_cnt_hold", bc_l, held);
      end
    end
    chk("gap_data", pd_l, 8'hA5);
    chk("gap_valid", pv_l, 1'b1);

    // Frame alignment: partial bits discarded
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("align_partial_cnt", bc_l, 3'd3);
    send_word(8'h3C, 0, 1'b1, 1'b1, 1'b1);
    chk("align_data_lsb", pd_l, 8'h3C);
    chk("align_data_msb", pd_m, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure, drop, clear, and load on a ready completion edge
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_first_data", pd_l, 8'h11);
    send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_data", pd_l, 8'h11);
    chk("bp_overrun", ov_l, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_clr", ov_l, 1'b0);
    send_word(8'h33, 0, 1'b0, 1'b1, 1'b0);
    chk("bp_load33", pd_l, 8'h33);
    chk("bp_load33_valid", pv_l, 1'b1);
    chk("bp_load33_ovr", ov_l, 1'b0);

    // Async reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_data", pd_l, 8'h00);
    chk("arst_data_msb", pd_m, 8'h00);
    chk("arst_valid", pv_l, 1'b0);
    chk("arst_ovr", ov_l, 1'b0);
    chk("arst_cnt", bc_l, 3'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    send_word(8'hFF, 0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_ff", pd_l, 8'hFF);
    chk("post_rst_ff_msb", pd_m, 8'hFF);
    chk("post_rst_valid", pv_l, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(99, 0) < 70),
           ($urandom_range(99, 0) < 5), 1'($urandom_range(1, 0)),
           ($urandom_range(99, 0) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
